// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Loads a framed byte stream into instruction memory and holds
//               the CPU in reset until a load ends with a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
   parameter int MEM_DEPTH = 128
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        MemWrite,
   output logic [15:0] MemAddress,
   output logic [7:0]  MemData,
   output logic        Busy,
   output logic        Done,
   output logic [1:0]  Error,
   output logic        HoldCpu
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_ADDR_HI = 4'd1,
      S_ADDR_LO = 4'd2,
      S_LEN_HI  = 4'd3,
      S_LEN_LO  = 4'd4,
      S_DATA    = 4'd5,
      S_CHECK   = 4'd6,
      S_DONE    = 4'd7,
      S_ERROR   = 4'd8
   } state_t;

   localparam logic [1:0] c_ERR_NONE  = 2'b00;
   localparam logic [1:0] c_ERR_RANGE = 2'b01;
   localparam logic [1:0] c_ERR_CSUM  = 2'b10;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [15:0] r_len;
   logic [15:0] r_count;
   logic [7:0]  r_csum;
   logic [1:0]  r_error;
   logic        r_mem_write;
   logic [15:0] r_mem_address;
   logic [7:0]  r_mem_data;

   logic        w_accept;
   logic        w_start;
   logic [15:0] w_len_full;
   logic [16:0] w_end;
   logic        w_range_err;
   logic [15:0] w_count_next;

   assign w_accept     = ByteValid & ByteReady;
   assign w_start      = Start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
   assign w_len_full   = {r_len[15:8], ByteIn};
   // 17-bit sum so an out-of-range frame cannot wrap back into range
   assign w_end        = {1'b0, r_addr} + {1'b0, w_len_full};
   assign w_range_err  = (w_end > 17'(MEM_DEPTH));
   assign w_count_next = r_count + 16'd1;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      ByteReady = 1'b0;
      Busy      = 1'b1;
      HoldCpu   = 1'b1;
      case (r_state)
         S_IDLE, S_ERROR: begin
            Busy = 1'b0;
            if (w_start) w_next = S_ADDR_HI;
         end
         S_DONE: begin
            Busy    = 1'b0;
            HoldCpu = 1'b0;
            if (w_start) w_next = S_ADDR_HI;
         end
         S_ADDR_HI: begin
            ByteReady = 1'b1;
            if (ByteValid) w_next = S_ADDR_LO;
         end
         S_ADDR_LO: begin
            ByteReady = 1'b1;
            if (ByteValid) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            ByteReady = 1'b1;
            if (ByteValid) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            ByteReady = 1'b1;
            if (ByteValid) begin
               if (w_range_err)              w_next = S_ERROR;
               else if (w_len_full == 16'd0) w_next = S_CHECK;
               else                          w_next = S_DATA;
            end
         end
         S_DATA: begin
            ByteReady = 1'b1;
            if (ByteValid && (w_count_next == r_len)) w_next = S_CHECK;
         end
         S_CHECK: begin
            ByteReady = 1'b1;
            if (ByteValid) w_next = (ByteIn == r_csum) ? S_DONE : S_ERROR;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_addr        <= 16'd0;
         r_len         <= 16'd0;
         r_count       <= 16'd0;
         r_csum        <= 8'd0;
         r_error       <= c_ERR_NONE;
         r_mem_write   <= 1'b0;
         r_mem_address <= 16'd0;
         r_mem_data    <= 8'd0;
      end else begin
         r_mem_write <= 1'b0;
         if (w_start) begin
            r_csum  <= 8'd0;
            r_count <= 16'd0;
            r_error <= c_ERR_NONE;
         end
         if (w_accept) begin
            case (r_state)
               S_ADDR_HI: r_addr[15:8] <= ByteIn;
               S_ADDR_LO: r_addr[7:0]  <= ByteIn;
               S_LEN_HI:  r_len[15:8]  <= ByteIn;
               S_LEN_LO: begin
                  r_len[7:0] <= ByteIn;
                  if (w_range_err) r_error <= c_ERR_RANGE;
               end
               S_DATA: begin
                  r_mem_write   <= 1'b1;
                  r_mem_address <= r_addr + r_count;
                  r_mem_data    <= ByteIn;
                  r_csum        <= r_csum ^ ByteIn;
                  r_count       <= w_count_next;
               end
               S_CHECK: begin
                  if (ByteIn != r_csum) r_error <= c_ERR_CSUM;
               end
               default: ;
            endcase
         end
      end
   end

   assign MemWrite   = r_mem_write;
   assign MemAddress = r_mem_address;
   assign MemData    = r_mem_data;
   assign Done       = (r_state == S_DONE);
   assign Error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Scoreboard bench for program_loader with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;
   typedef logic [7:0] bq_t[$];

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'h00;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic        MemWrite;
   logic [15:0] MemAddress;
   logic [7:0]  MemData;
   logic        Busy;
   logic        Done;
   logic [1:0]  Error;
   logic        HoldCpu;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   wr_t  exp_q[$];
   int   wr_cyc_q[$];
   wr_t  mon_e;

   program_loader #(.MEM_DEPTH(128)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .ByteIn(ByteIn),
      .ByteValid(ByteValid), .ByteReady(ByteReady), .MemWrite(MemWrite),
      .MemAddress(MemAddress), .MemData(MemData), .Busy(Busy), .Done(Done),
      .Error(Error), .HoldCpu(HoldCpu)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // Write monitor: every strobe must match the oldest expected write
   always @(negedge Clock) begin
      if (MemWrite === 1'b1) begin
         wr_cyc_q.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write", MemAddress, MemData);
         end else begin
            mon_e = exp_q.pop_front();
            if (MemAddress !== mon_e.a || MemData !== mon_e.d) begin
               n_fail++;
               $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                        MemAddress, MemData, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
      exp_q.push_back('{a: a, d: d});
   endtask

   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      ByteValid = 1'b0;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t = 0;
      @(negedge Clock);
      ByteIn = b;
      ByteValid = 1'b1;
      while (ByteReady !== 1'b1 && t < 50) begin
         @(negedge Clock);
         t++;
      end
      if (ByteReady !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got ByteReady %b, required 1 for byte %0h", ByteReady, b);
         ByteValid = 1'b0;
         return;
      end
      @(posedge Clock);
      if (gap > 0) begin
         @(negedge Clock);
         ByteValid = 1'b0;
         repeat (gap - 1) @(negedge Clock);
      end
   endtask

   task automatic send_frame(input bq_t bytes, input int gap);
      foreach (bytes[i]) send_byte(bytes[i], gap);
   endtask

   task automatic check_status(input string name, input logic done, input logic [1:0] err,
                               input logic hold);
      @(negedge Clock);
      ByteValid = 1'b0;
      check({name, "_done"},  {15'd0, Done}, {15'd0, done});
      check({name, "_error"}, {14'd0, Error}, {14'd0, err});
      check({name, "_hold"},  {15'd0, HoldCpu}, {15'd0, hold});
      check({name, "_busy"},  {15'd0, Busy}, 16'd0);
      check({name, "_ready"}, {15'd0, ByteReady}, 16'd0);
      check({name, "_pending_writes"}, 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      repeat (3) @(negedge Clock);
      check("rst_ready", {15'd0, ByteReady}, 16'd0);
      check("rst_memwrite", {15'd0, MemWrite}, 16'd0);
      check("rst_addr", MemAddress, 16'd0);
      check("rst_data", {8'd0, MemData}, 16'd0);
      check("rst_busy", {15'd0, Busy}, 16'd0);
      check("rst_done", {15'd0, Done}, 16'd0);
      check("rst_error", {14'd0, Error}, 16'd0);
      check("rst_hold", {15'd0, HoldCpu}, 16'd1);
      Reset = 1'b0;

      // Test 1: streamed frame, writes on consecutive cycles
      wr_cyc_q.delete();
      pulse_start();
      check("t1_busy", {15'd0, Busy}, 16'd1);
      expect_wr(16'd9, 8'h91); expect_wr(16'd10, 8'h02);
      expect_wr(16'd11, 8'h93); expect_wr(16'd12, 8'h04);
      send_frame('{8'h00, 8'h09, 8'h00, 8'h04, 8'h91, 8'h02, 8'h93, 8'h04, 8'h04}, 0);
      check_status("t1", 1'b1, 2'b00, 1'b0);
      check("t1_nwrites", 16'(wr_cyc_q.size()), 16'd4);
      if (wr_cyc_q.size() == 4)
         check("t1_backtoback", 16'(wr_cyc_q[3] - wr_cyc_q[0]), 16'd3);

      // Test 2: same frame, toggling valid and a long payload gap
      pulse_start();
      expect_wr(16'd9, 8'h91); expect_wr(16'd10, 8'h02);
      expect_wr(16'd11, 8'h93); expect_wr(16'd12, 8'h04);
      send_frame('{8'h00, 8'h09, 8'h00, 8'h04, 8'h91}, 1);
      send_byte(8'h02, 5);
      send_frame('{8'h93, 8'h04, 8'h04}, 1);
      check_status("t2", 1'b1, 2'b00, 1'b0);

      // Test 3: range error, then the exact-fit boundary frame
      pulse_start();
      send_frame('{8'h00, 8'h7E, 8'h00, 8'h03}, 0);
      check_status("t3_range", 1'b0, 2'b01, 1'b1);
      pulse_start();
      expect_wr(16'h7D, 8'h11); expect_wr(16'h7E, 8'h22); expect_wr(16'h7F, 8'h33);
      send_frame('{8'h00, 8'h7D, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00}, 0);
      check_status("t3_fit", 1'b1, 2'b00, 1'b0);

      // Test 4: bad checksum, then recovery
      pulse_start();
      expect_wr(16'h00, 8'hAA); expect_wr(16'h01, 8'h55);
      send_frame('{8'h00, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h00}, 0);
      check_status("t4_bad", 1'b0, 2'b10, 1'b1);
      pulse_start();
      expect_wr(16'h20, 8'h5A);
      send_frame('{8'h00, 8'h20, 8'h00, 8'h01, 8'h5A, 8'h5A}, 0);
      check_status("t4_good", 1'b1, 2'b00, 1'b0);

      // Test 5: empty payloads
      pulse_start();
      send_frame('{8'h00, 8'h10, 8'h00, 8'h00, 8'h00}, 0);
      check_status("t5_ok", 1'b1, 2'b00, 1'b0);
      pulse_start();
      send_frame('{8'h00, 8'h10, 8'h00, 8'h00, 8'h01}, 0);
      check_status("t5_bad", 1'b0, 2'b10, 1'b1);

      // Test 6: reset mid-load, then Start ignored while busy
      pulse_start();
      expect_wr(16'd9, 8'h91); expect_wr(16'd10, 8'h02);
      send_frame('{8'h00, 8'h09, 8'h00, 8'h04, 8'h91, 8'h02}, 0);
      @(negedge Clock);
      ByteIn = 8'h93;
      ByteValid = 1'b1;
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      ByteValid = 1'b0;
      check("t6_busy", {15'd0, Busy}, 16'd0);
      check("t6_hold", {15'd0, HoldCpu}, 16'd1);
      check("t6_ready", {15'd0, ByteReady}, 16'd0);
      check("t6_memwrite", {15'd0, MemWrite}, 16'd0);
      check("t6_addr", MemAddress, 16'd0);
      repeat (2) @(negedge Clock);
      check("t6_pending_writes", 16'(exp_q.size()), 16'd0);

      pulse_start();
      expect_wr(16'd9, 8'h91); expect_wr(16'd10, 8'h02);
      expect_wr(16'd11, 8'h93); expect_wr(16'd12, 8'h04);
      send_frame('{8'h00, 8'h09, 8'h00, 8'h04, 8'h91, 8'h02}, 0);
      pulse_start();
      send_frame('{8'h93, 8'h04, 8'h04}, 0);
      check_status("t6_busy_start", 1'b1, 2'b00, 1'b0);

      repeat (3) @(negedge Clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
